// File: rtl/div_pkg.sv
// Shared opcodes and FSM encodings for the EX-stage integer divider.
package div_pkg;

  localparam logic [7:0]  EXE_DIV_OP    = 8'b0001_1010;
  localparam logic [7:0]  EXE_DIVU_OP   = 8'b0001_1011;
  localparam logic [7:0]  EXE_ADD_OP    = 8'b0010_0000;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: magnitude on the way in, sign restore on the way out.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  // -0x80..0 wraps to itself, which read as unsigned is exactly 2^(WIDTH-1)
  assign res = neg ? -val : val;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (quotient on lo_o, remainder on hi_o).
// Optional DIV_EARLY_EXIT_EN: skip iterations when |divisor| > |dividend|.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       alucontrol,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r;

  logic             sgn_in, accept, zero_div, early;
  logic [WIDTH:0]   rem_w;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n;

  // index 0: dividend / quotient, index 1: divisor / remainder
  logic [1:0][WIDTH-1:0] pre_in, pre_out, post_in, post_out;
  logic [1:0]            pre_neg, post_neg;

  assign sgn_in   = (alucontrol == EXE_DIV_OP);
  assign accept   = start_i & ~flush_i & is_div_op(alucontrol);
  assign pre_in   = {opb_i, opa_i};
  assign pre_neg  = {sgn_in & opb_i[WIDTH-1], sgn_in & opa_i[WIDTH-1]};
  assign post_in  = {rem_n, quo_n};
  assign post_neg = {neg_r, neg_q};
  assign zero_div = (opb_i == '0);

  for (genvar g = 0; g < 2; g++) begin : g_fix
    div_sign_fix #(.WIDTH(WIDTH)) u_pre (
      .val(pre_in[g]), .neg(pre_neg[g]), .res(pre_out[g])
    );
    div_sign_fix #(.WIDTH(WIDTH)) u_post (
      .val(post_in[g]), .neg(post_neg[g]), .res(post_out[g])
    );
  end

`ifdef DIV_EARLY_EXIT_EN
  assign early = ~zero_div & (pre_out[1] > pre_out[0]);
`else
  assign early = 1'b0;
`endif

  // One restoring step; the shifted partial remainder needs WIDTH+1 bits
  // because an unsigned divisor may use the full word.
  always_comb begin
    rem_w = {rem, quo[WIDTH-1]};
    ge    = (rem_w >= {1'b0, dvs});
    rem_n = ge ? WIDTH'(rem_w - {1'b0, dvs}) : rem_w[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
  end

  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    ready_o = 1'b0;
    case (state)
      DIV_IDLE: begin
        stall_o = accept;
        if (accept) state_n = (zero_div | early) ? DIV_DONE : DIV_BUSY;
      end
      DIV_BUSY: begin
        stall_o = 1'b1;
        if (cnt == LAST) state_n = DIV_DONE;
      end
      DIV_DONE: begin
        ready_o = 1'b1;
        state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
    if (flush_i) begin
      state_n = DIV_IDLE;
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      lo_o  <= '0;
      hi_o  <= '0;
    end else begin
      state <= state_n;
      if (flush_i) begin
        cnt <= '0;
      end else begin
        case (state)
          DIV_IDLE: if (accept) begin
            rem   <= '0;
            quo   <= pre_out[0];
            dvs   <= pre_out[1];
            neg_q <= sgn_in & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
            neg_r <= sgn_in & opa_i[WIDTH-1];
            cnt   <= '0;
            if (zero_div) begin
              lo_o <= '1;
              hi_o <= opa_i;
            end else if (early) begin
              lo_o <= '0;
              hi_o <= opa_i;
            end
          end
          DIV_BUSY: begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              lo_o <= post_out[0];
              hi_o <= post_out[1];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start_i, flush_i;
  logic [7:0]  alucontrol;
  logic [31:0] opa_i, opb_i, lo_o, hi_o;
  logic        stall_o, ready_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_q = '0, last_r = '0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .alucontrol(alucontrol), .start_i(start_i),
    .flush_i(flush_i), .opa_i(opa_i), .opb_i(opb_i), .stall_o(stall_o),
    .ready_o(ready_o), .lo_o(lo_o), .hi_o(hi_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Quotient/remainder from plain integer arithmetic; latency from the op rules.
  function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    int sa, sb;
    lat = 33;
    if (b == 0) begin
      q = DIV_ZERO_QUOT; r = a; lat = 1;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
`ifdef DIV_EARLY_EXIT_EN
    begin
      logic [31:0] ma, mb;
      ma = (sgn && a[31]) ? -a : a;
      mb = (sgn && b[31]) ? -b : b;
      if (b != 0 && mb > ma) lat = 1;
    end
`endif
  endfunction

  // Accept on the next negedge, scramble the idle inputs afterwards, wait for the strobe.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eq, er;
    int lat, got;
    bit stall_bad;
    model(op == EXE_DIV_OP, a, b, eq, er, lat);
    @(negedge clk);
    alucontrol = op; start_i = 1'b1; opa_i = a; opb_i = b;
    #1;
    chk({tag, "/accept_stall"}, 32'(stall_o), 32'd1);
    chk({tag, "/idle_ready"}, 32'(ready_o), 32'd0);
    got = 0; stall_bad = 0;
    for (int k = 1; k <= 40 && got == 0; k++) begin
      @(negedge clk);
      if (ready_o) got = k;
      if (stall_o !== (k < lat)) stall_bad = 1;
      start_i = 1'b0; alucontrol = 8'($urandom); opa_i = $urandom; opb_i = $urandom;
    end
    chk({tag, "/latency"}, 32'(got), 32'(lat));
    chk({tag, "/stall_window"}, 32'(stall_bad), 32'd0);
    chk({tag, "/lo"}, lo_o, eq);
    chk({tag, "/hi"}, hi_o, er);
    last_q = eq; last_r = er;
  endtask

  // Accept DIVU 100/7 and abort it ten cycles later with flush (kind=0) or rst (kind=1).
  task automatic abort_op(input string tag, input bit kind);
    bit saw_ready = 0;
    @(negedge clk);
    alucontrol = EXE_DIVU_OP; start_i = 1'b1; opa_i = 32'd100; opb_i = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready_o) saw_ready = 1;
      start_i = 1'b0;
    end
    if (kind) rst = 1'b1; else flush_i = 1'b1;
    #1;
    if (!kind) chk({tag, "/flush_stall"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0;
    #1;
    if (ready_o) saw_ready = 1;
    chk({tag, "/no_ready"}, 32'(saw_ready), 32'd0);
    chk({tag, "/stall"}, 32'(stall_o), 32'd0);
    if (kind) begin
      last_q = '0; last_r = '0;
    end
    chk({tag, "/lo_hold"}, lo_o, last_q);
    chk({tag, "/hi_hold"}, hi_o, last_r);
  endtask

  // Present a request that must not be accepted and confirm nothing happens.
  task automatic no_accept(input string tag, input logic [7:0] op, input bit flush);
    bit bad = 0;
    @(negedge clk);
    alucontrol = op; start_i = 1'b1; flush_i = flush; opa_i = 32'd50; opb_i = 32'd5;
    #1;
    chk({tag, "/stall"}, 32'(stall_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o || stall_o) bad = 1;
    end
    chk({tag, "/idle"}, 32'(bad), 32'd0);
    chk({tag, "/lo_hold"}, lo_o, last_q);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; alucontrol = '0; opa_i = '0; opb_i = '0;
    repeat (2) @(negedge clk);
    chk("reset/lo", lo_o, 32'd0);
    chk("reset/hi", hi_o, 32'd0);
    chk("reset/ready", 32'(ready_o), 32'd0);
    chk("reset/stall", 32'(stall_o), 32'd0);
    rst = 1'b0;

    run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7);
    run_op("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
    run_op("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE);
    run_op("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max_1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1);
    run_op("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0);
    run_op("div_m9_0", EXE_DIV_OP, 32'hFFFF_FFF7, 32'd0);
    run_op("divu_3_10", EXE_DIVU_OP, 32'd3, 32'd10);
    run_op("div_m3_10", EXE_DIV_OP, 32'hFFFF_FFFD, 32'd10);
    run_op("div_min_2", EXE_DIV_OP, 32'h8000_0000, 32'd2);

    abort_op("flush", 1'b0);
    run_op("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3);
    abort_op("rst", 1'b1);
    run_op("after_rst", EXE_DIVU_OP, 32'd9, 32'd3);

    no_accept("add_op", EXE_ADD_OP, 1'b0);
    no_accept("div_flush", EXE_DIV_OP, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [7:0]  op;
      op = ($urandom_range(0, 1) != 0) ? EXE_DIV_OP : EXE_DIVU_OP;
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(256, 4096)); end
        3: a = 32'h8000_0000;
        4: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage. It is the consumer end of the decoder's alucontrol bus.
- Accepts EXE_DIV_OP / EXE_DIVU_OP codes plus operands, iterates radix-2 restoring division, and returns quotient (LO) and remainder (HI).
- Asserts stall while busy so the pipeline freezes EX until the result is ready.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- alucontrol  in  8  ALU op code from the decoder; only EXE_DIV_OP / EXE_DIVU_OP (defines.vh) start the unit.
- start_i  in  1  EX-stage instruction valid; acceptance requires start_i=1 with a div op.
- flush_i  in  1  exception/ERET cancel; aborts any operation.
- opa_i  in  WIDTH  dividend (rs).
- opb_i  in  WIDTH  divisor (rt).
- stall_o  out  1  pipeline hold request.
- ready_o  out  1  one-cycle result-valid strobe.
- lo_o  out  WIDTH  quotient.
- hi_o  out  WIDTH  remainder.

Behaviour:
- Reset: state=IDLE; counter=0; lo_o=0, hi_o=0, ready_o=0, stall_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - accept = start_i & ~flush_i & (alucontrol==EXE_DIV_OP | alucontrol==EXE_DIVU_OP).
  - stall_o = accept, combinational in the same cycle, so EX freezes immediately.
  - On accept: latch operands and the signed flag (DIV=1, DIVU=0).
  - Operand conversion: signed uses absolute values; the most-negative value 0x80000000 is treated as unsigned 2^31.
  - Divisor==0 -> DONE next cycle. Otherwise -> BUSY with counter=0.
- BUSY:
  - stall_o=1.
  - Each cycle: shift {rem,quo} left 1; trial-subtract the divisor from the upper half; keep if non-negative and set quotient LSB=1, else restore.
  - Counter increments each cycle; after WIDTH iterations -> DONE.
  - Unaccepted alucontrol/start changes are ignored.
- DONE:
  - ready_o=1 and stall_o=0 for exactly one cycle, then -> IDLE unconditionally.
  - lo_o/hi_o update on entry to DONE and hold until the next DONE.
- Latency:
  - Accept at cycle c, ready_o at cycle c+WIDTH+1 (c+33 default). stall_o is high in cycles c..c+32.
  - Divide-by-zero: ready_o at c+1.
- Sign fix (signed only):
  - quotient negated if opa sign != opb sign.
  - remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
- Divide-by-zero result: lo=0xFFFFFFFF, hi=opa_i as latched, for both signed and unsigned. No exception.
- flush_i:
  - In any state: next state IDLE, counter cleared, ready_o=0 next cycle, stall_o=0 combinationally.
  - lo_o/hi_o keep their previous values.
  - flush_i has priority over accept and over DONE.
- rst mid-operation: identical to the reset values above. No partial result is ever published.
- Back-to-back: a new accept is possible in the IDLE cycle directly after DONE.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if |divisor| > |dividend| (unsigned magnitude compare) and divisor != 0, go directly to DONE.
  - Result: lo=0, hi=dividend (original, sign preserved); ready_o at c+1.
- Undefined: always WIDTH iterations. Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package/defines.vh: EXE_DIV_OP and EXE_DIVU_OP codes (already present), FSM state encodings (DIV_IDLE/DIV_BUSY/DIV_DONE), DIV_ZERO_QUOT=32'hFFFFFFFF.
- One natural sub-module: div_sign_fix (combinational absolute-value in / sign-restore out), reused for operand pre-processing and result post-processing.
- Iteration datapath and FSM stay in div_unit.

Test Plan:
- DIVU 100/7, accept at c -> stall_o high c..c+32; ready_o at c+33; lo=14, hi=2.
- DIV -7/2 (0xFFFFFFF9/0x2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7/-2 -> lo=-3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
- Divisor 0 (DIVU 5/0) -> ready_o at c+1; lo=0xFFFFFFFF, hi=5.
- Accept DIVU 100/7, assert flush_i at c+10 -> IDLE at c+11, no ready_o pulse; lo/hi unchanged. Then DIVU 9/3 starts the next cycle -> lo=3, hi=0 at +33. Repeat with rst at c+10: all outputs zero.
- DIV_EARLY_EXIT_EN defined: DIVU 3/10 -> ready_o at c+1, lo=0, hi=3. Undefined: same values at c+33. ADD_OP with start_i=1 -> never accepted, stall_o=0.
